// File: rtl/output_buffer_ctrl.sv
// Partial-output buffer sequencer for one output tile: clears every entry, accumulates
// lane-wise partial sums with a single-cycle read-modify-write, then drains entries in order.
module output_buffer_ctrl #(
    parameter int BUF_NUM = 8,
    parameter int DAT_W   = 64,
    parameter int LANE_W  = 16,
    parameter int SEL_W   = $clog2(BUF_NUM)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       pass_num_i,
    input  logic             psum_val_i,
    input  logic [SEL_W-1:0] psum_sel_i,
    input  logic [DAT_W-1:0] psum_dat_i,
    output logic             psum_rdy_o,
    output logic [SEL_W-1:0] acc_sel_o,
    output logic             acc_val_o,
    output logic [DAT_W-1:0] acc_dat_o,
    input  logic [DAT_W-1:0] acc_dat_i,
    output logic [SEL_W-1:0] out_sel_o,
    input  logic [DAT_W-1:0] out_dat_i,
    output logic             out_val_o,
    output logic [DAT_W-1:0] out_dat_o,
    input  logic             out_rdy_i,
    output logic             busy_o,
    output logic             done_o
);
    localparam int LANES  = DAT_W / LANE_W;
    localparam int BEAT_W = 8 + SEL_W + 1;
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(BUF_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACCUM = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e            state_q;
    logic [SEL_W-1:0]  clr_cnt_q;
    logic [SEL_W-1:0]  drn_cnt_q;
    logic [BEAT_W-1:0] beat_cnt_q;
    logic [7:0]        pass_q;
    logic              clr_q;
    logic              rdy_q;
    logic              drn_q;
    logic              busy_q;
    logic              done_q;

    logic              psum_hs_s;
    logic              sel_ok_s;
    logic              acc_wr_s;
    logic              last_beat_s;
    logic [BEAT_W-1:0] beat_tgt_s;

    function automatic logic [DAT_W-1:0] lane_add(input logic [DAT_W-1:0] a,
                                                  input logic [DAT_W-1:0] b);
        logic [DAT_W-1:0] sum;
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            sum[l*LANE_W +: LANE_W] = a[l*LANE_W +: LANE_W] + b[l*LANE_W +: LANE_W];
        end
        return sum;
    endfunction

    // Out-of-range selects exist only when BUF_NUM is not a power of two.
    if (BUF_NUM == (1 << SEL_W)) begin : g_sel_full
        assign sel_ok_s = 1'b1;
    end else begin : g_sel_part
        assign sel_ok_s = (psum_sel_i < SEL_W'(BUF_NUM));
    end

    assign psum_hs_s   = psum_val_i & rdy_q;
    assign acc_wr_s    = psum_hs_s & sel_ok_s & ~clr_q;
    assign beat_tgt_s  = BEAT_W'(pass_q) * BEAT_W'(BUF_NUM);
    assign last_beat_s = ((beat_cnt_q + BEAT_W'(1)) == beat_tgt_s);

    // Tile sequencer: state, counters and the registered status/strobe flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            drn_cnt_q  <= '0;
            beat_cnt_q <= '0;
            pass_q     <= 8'd0;
            clr_q      <= 1'b0;
            rdy_q      <= 1'b0;
            drn_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        pass_q     <= pass_num_i;
                        clr_cnt_q  <= '0;
                        beat_cnt_q <= '0;
                        clr_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == LAST_SEL) begin
                        clr_cnt_q <= '0;
                        clr_q     <= 1'b0;
                        if (pass_q == 8'd0) begin
                            drn_q   <= 1'b1;
                            state_q <= S_DRAIN;
                        end else begin
                            rdy_q   <= 1'b1;
                            state_q <= S_ACCUM;
                        end
                    end else begin
                        clr_cnt_q <= clr_cnt_q + SEL_W'(1);
                    end
                end
                S_ACCUM: begin
                    if (psum_hs_s) begin
                        if (last_beat_s) begin
                            beat_cnt_q <= '0;
                            rdy_q      <= 1'b0;
                            drn_q      <= 1'b1;
                            state_q    <= S_DRAIN;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_rdy_i) begin
                        if (drn_cnt_q == LAST_SEL) begin
                            drn_cnt_q <= '0;
                            drn_q     <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            drn_cnt_q <= drn_cnt_q + SEL_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    clr_q   <= 1'b0;
                    rdy_q   <= 1'b0;
                    drn_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Buffer accumulate-port select/enable: clear sweep or the accepted beat's entry.
    always_comb begin
        acc_val_o = 1'b0;
        acc_sel_o = '0;
        if (clr_q) begin
            acc_val_o = 1'b1;
            acc_sel_o = clr_cnt_q;
        end else if (acc_wr_s) begin
            acc_val_o = 1'b1;
            acc_sel_o = psum_sel_i;
        end else begin
            acc_val_o = 1'b0;
            acc_sel_o = '0;
        end
    end

    // Write data is kept apart from the select so the buffer read path forms no loop.
    assign acc_dat_o  = acc_wr_s ? lane_add(acc_dat_i, psum_dat_i) : '0;
    assign out_sel_o  = drn_cnt_q;
    assign out_val_o  = drn_q;
    assign out_dat_o  = drn_q ? out_dat_i : '0;
    assign psum_rdy_o = rdy_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_output_buffer_ctrl.sv
// Bench for output_buffer_ctrl: behavioural buffer plus a lane-sum reference model,
// directed tiles followed by randomized tiles.
module tb_output_buffer_ctrl;
    localparam int BN = 4;
    localparam int DW = 64;
    localparam int LW = 16;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [7:0]    pass_num_i;
    logic          psum_val_i;
    logic [SW-1:0] psum_sel_i;
    logic [DW-1:0] psum_dat_i;
    logic          psum_rdy_o;
    logic [SW-1:0] acc_sel_o;
    logic          acc_val_o;
    logic [DW-1:0] acc_dat_o;
    logic [DW-1:0] acc_dat_i;
    logic [SW-1:0] out_sel_o;
    logic [DW-1:0] out_dat_i;
    logic          out_val_o;
    logic [DW-1:0] out_dat_o;
    logic          out_rdy_i;
    logic          busy_o;
    logic          done_o;

    logic [DW-1:0] mem [BN];
    logic          garble;
    logic [DW-1:0] exp_buf [BN];
    logic [SW-1:0] q_sel [$];
    logic [DW-1:0] q_dat [$];
    int            tests;
    int            fails;

    always #5 clk = ~clk;

    output_buffer_ctrl #(.BUF_NUM(BN), .DAT_W(DW), .LANE_W(LW)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pass_num_i(pass_num_i),
        .psum_val_i(psum_val_i), .psum_sel_i(psum_sel_i), .psum_dat_i(psum_dat_i),
        .psum_rdy_o(psum_rdy_o), .acc_sel_o(acc_sel_o), .acc_val_o(acc_val_o),
        .acc_dat_o(acc_dat_o), .acc_dat_i(acc_dat_i), .out_sel_o(out_sel_o),
        .out_dat_i(out_dat_i), .out_val_o(out_val_o), .out_dat_o(out_dat_o),
        .out_rdy_i(out_rdy_i), .busy_o(busy_o), .done_o(done_o)
    );

    assign acc_dat_i = mem[acc_sel_o];
    assign out_dat_i = mem[out_sel_o];

    // Behavioural buffer: random fill on request, otherwise writes from the accumulate port.
    always @(posedge clk) begin
        if (garble) begin
            for (int i = 0; i < BN; i++) mem[i] <= {$urandom, $urandom};
        end else if (acc_val_o) begin
            mem[acc_sel_o] <= acc_dat_o;
        end
    end

    function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] r;
        longint unsigned x, y;
        r = 64'd0;
        for (int l = 0; l < 4; l++) begin
            x = (a >> (16 * l)) & 64'hFFFF;
            y = (b >> (16 * l)) & 64'hFFFF;
            r = r | (((x + y) % 64'd65536) << (16 * l));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},  64'(psum_rdy_o), 64'd0);
        chk({tag, "_aval"}, 64'(acc_val_o),  64'd0);
        chk({tag, "_asel"}, 64'(acc_sel_o),  64'd0);
        chk({tag, "_adat"}, acc_dat_o,       64'd0);
        chk({tag, "_osel"}, 64'(out_sel_o),  64'd0);
        chk({tag, "_oval"}, 64'(out_val_o),  64'd0);
        chk({tag, "_odat"}, out_dat_o,       64'd0);
        chk({tag, "_busy"}, 64'(busy_o),     64'd0);
        chk({tag, "_done"}, 64'(done_o),     64'd0);
    endtask

    // drain_mode: 0 always ready, 1 random ready, 2 three-cycle hold on entry 1.
    task automatic run_tile(input int pass, input bit nostall, input int drain_mode,
                            input int abort_after);
        int cyc, idx, k, guard, hold, limit;
        bit v;
        logic [SW-1:0] s;
        logic [DW-1:0] d;
        @(negedge clk); garble = 1'b1;
        @(negedge clk); garble = 1'b0;
        start_i = 1'b1; pass_num_i = 8'(pass); psum_val_i = 1'b0; out_rdy_i = 1'b0;
        #1;
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_rdy", 64'(psum_rdy_o), 64'd0);
        cyc = 1;
        for (int i = 0; i < BN; i++) begin
            @(negedge clk); cyc++;
            start_i = 1'($urandom); pass_num_i = 8'($urandom);
            psum_val_i = 1'($urandom); psum_sel_i = 2'($urandom); psum_dat_i = {$urandom, $urandom};
            #1;
            chk("clr_val", 64'(acc_val_o), 64'd1);
            chk("clr_sel", 64'(acc_sel_o), 64'(i));
            chk("clr_dat", acc_dat_o, 64'd0);
            chk("clr_rdy", 64'(psum_rdy_o), 64'd0);
            chk("clr_busy", 64'(busy_o), 64'd1);
            exp_buf[i] = 64'd0;
        end
        limit = (abort_after >= 0) ? abort_after : q_sel.size();
        idx = 0; guard = 0;
        while (idx < limit && guard < 2000) begin
            @(negedge clk); cyc++; guard++;
            v = nostall || ($urandom_range(3) != 0);
            s = q_sel[idx]; d = q_dat[idx];
            psum_val_i = v;
            psum_sel_i = v ? s : 2'($urandom);
            psum_dat_i = v ? d : {$urandom, $urandom};
            start_i = 1'($urandom);
            #1;
            chk("acc_rdy", 64'(psum_rdy_o), 64'd1);
            if (v) begin
                exp_buf[s] = lane_add(exp_buf[s], d);
                chk("acc_val", 64'(acc_val_o), 64'd1);
                chk("acc_sel", 64'(acc_sel_o), 64'(s));
                chk("acc_dat", acc_dat_o, exp_buf[s]);
                idx++;
            end else begin
                chk("acc_gap_val", 64'(acc_val_o), 64'd0);
                chk("acc_gap_dat", acc_dat_o, 64'd0);
            end
        end
        chk("accum_beats", 64'(idx), 64'(limit));
        if (abort_after >= 0) begin
            @(negedge clk);
            psum_val_i = 1'b1; rst_i = 1'b1;
            #1;
            chk_zero("rst_mid");
            @(negedge clk);
            rst_i = 1'b0; psum_val_i = 1'b0; start_i = 1'b0;
            return;
        end
        k = 0; hold = 0; guard = 0;
        while (k < BN && guard < 2000) begin
            @(negedge clk); cyc++; guard++;
            psum_val_i = 1'($urandom); psum_sel_i = 2'($urandom);
            psum_dat_i = {$urandom, $urandom}; start_i = 1'($urandom);
            case (drain_mode)
                0: out_rdy_i = 1'b1;
                1: out_rdy_i = 1'($urandom);
                default: begin
                    out_rdy_i = !(k == 1 && hold < 3);
                    if (k == 1 && hold < 3) hold++;
                end
            endcase
            #1;
            chk("drn_val", 64'(out_val_o), 64'd1);
            chk("drn_sel", 64'(out_sel_o), 64'(k));
            chk("drn_dat", out_dat_o, exp_buf[k]);
            chk("drn_rdy", 64'(psum_rdy_o), 64'd0);
            chk("drn_nowr", 64'(acc_val_o), 64'd0);
            if (out_rdy_i) k++;
        end
        chk("drain_beats", 64'(k), 64'(BN));
        if (drain_mode == 2) chk("drain_hold", 64'(hold), 64'd3);
        @(negedge clk); cyc++;
        psum_val_i = 1'b0; out_rdy_i = 1'($urandom); start_i = 1'($urandom);
        #1;
        chk("done_pulse", 64'(done_o), 64'd1);
        chk("done_busy", 64'(busy_o), 64'd1);
        chk("done_oval", 64'(out_val_o), 64'd0);
        chk("done_odat", out_dat_o, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        #1;
        chk("post_done", 64'(done_o), 64'd0);
        chk("post_busy", 64'(busy_o), 64'd0);
        if (nostall && drain_mode == 0)
            chk("tile_cycles", 64'(cyc), 64'(1 + BN + pass * BN + BN + 1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        tests = 0; fails = 0;
        rst_i = 1'b1; start_i = 1'b0; pass_num_i = 8'd0; psum_val_i = 1'b0;
        psum_sel_i = '0; psum_dat_i = '0; out_rdy_i = 1'b0; garble = 1'b0;
        #1;
        chk_zero("rst_async");
        repeat (2) @(negedge clk);
        #1;
        chk_zero("rst_hold");
        @(negedge clk); rst_i = 1'b0;

        // basic accumulate: two passes of 1 per lane
        q_sel.delete(); q_dat.delete();
        for (int i = 0; i < 8; i++) begin
            q_sel.push_back(2'(i % 4)); q_dat.push_back(64'h0001_0001_0001_0001);
        end
        run_tile(2, 1'b1, 0, -1);

        // lane wrap on entry 0
        q_sel.delete(); q_dat.delete();
        for (int i = 0; i < 8; i++) begin
            q_sel.push_back(2'(i % 4));
            q_dat.push_back(i == 0 ? 64'hFFFF_FFFF_FFFF_FFFF :
                            i == 4 ? 64'h0003_0003_0003_0003 : 64'd0);
        end
        run_tile(2, 1'b1, 0, -1);

        // drain backpressure on entry 1
        q_sel.delete(); q_dat.delete();
        for (int i = 0; i < 4; i++) begin
            q_sel.push_back(2'(i)); q_dat.push_back({$urandom, $urandom});
        end
        run_tile(1, 1'b0, 2, -1);

        // zero passes
        q_sel.delete(); q_dat.delete();
        run_tile(0, 1'b1, 0, -1);

        // reset mid-accumulate, then a clean single-pass tile
        q_sel.delete(); q_dat.delete();
        for (int i = 0; i < 8; i++) begin
            q_sel.push_back(2'($urandom)); q_dat.push_back({$urandom, $urandom});
        end
        run_tile(2, 1'b1, 0, 3);
        q_sel.delete(); q_dat.delete();
        for (int i = 0; i < 4; i++) begin
            q_sel.push_back(2'($urandom)); q_dat.push_back({$urandom, $urandom});
        end
        run_tile(1, 1'b1, 0, -1);

        // same-entry streaming with start pulses while busy
        q_sel.delete(); q_dat.delete();
        for (int i = 0; i < 4; i++) begin
            q_sel.push_back(2'd2); q_dat.push_back(64'h0005_0005_0005_0005);
        end
        run_tile(1, 1'b1, 0, -1);

        // randomized tiles
        for (int t = 0; t < 8; t++) begin
            p = $urandom_range(1, 12);
            q_sel.delete(); q_dat.delete();
            for (int i = 0; i < p * BN; i++) begin
                q_sel.push_back(2'($urandom)); q_dat.push_back({$urandom, $urandom});
            end
            run_tile(p, 1'($urandom), int'($urandom_range(0, 1)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/output_buffer_ctrl.md
Name: output_buffer_ctrl

Overview:
Controller that sequences the partial-output buffer for one output tile. On start it clears every buffer entry. It then accepts partial-sum vectors over a valid/ready port and accumulates them into the selected entry with a single-cycle read-modify-write. After the programmed number of passes it drains every entry, in index order, over a valid/ready output stream. It sits between the MAC array (partial-sum producer) and the writeback path (drain consumer) and owns both buffer ports.

Parameters:
BUF_NUM, 8, number of buffer entries (matches `OUTPUT_BUF_NUM)
DAT_W, 64, entry width in bits (matches `BUF_SIZE)
LANE_W, 16, lane width; DAT_W must be a multiple of LANE_W; LANES = DAT_W/LANE_W
SEL_W, $clog2(BUF_NUM), entry select width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
start_i  in  1  begin tile; sampled only in IDLE
pass_num_i  in  8  accumulation passes per entry; latched on accepted start
psum_val_i  in  1  partial-sum beat valid
psum_sel_i  in  SEL_W  target entry of beat
psum_dat_i  in  DAT_W  partial-sum vector
psum_rdy_o  out  1  beat accepted when psum_val_i & psum_rdy_o
acc_sel_o  out  SEL_W  buffer accumulate-port select
acc_val_o  out  1  buffer write enable
acc_dat_o  out  DAT_W  buffer write data
acc_dat_i  in  DAT_W  buffer combinational read of acc_sel_o
out_sel_o  out  SEL_W  buffer drain-port select
out_dat_i  in  DAT_W  buffer combinational read of out_sel_o
out_val_o  out  1  drain beat valid
out_dat_o  out  DAT_W  drain data
out_rdy_i  in  1  drain consumer ready
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse at tile end

Behaviour:
- Reset (async assert; deassertion synchronous to clk_i): state IDLE, all counters 0. All outputs are 0: psum_rdy_o, acc_val_o, acc_sel_o, acc_dat_o, out_sel_o, out_val_o, out_dat_o, busy_o, done_o.
- Reset mid-operation aborts immediately. The controller does not touch buffer contents; the buffer has its own reset.
- States and transitions:
  - IDLE: start_i=1 latches pass_num_i and goes to CLEAR.
  - CLEAR: lasts BUF_NUM cycles. acc_val_o=1, acc_sel_o=clear counter (0..BUF_NUM-1), acc_dat_o=0. After the last entry: go to DRAIN if the latched pass_num=0, otherwise go to ACCUM.
  - ACCUM: psum_rdy_o=1. On a handshake in a cycle: acc_sel_o=psum_sel_i, acc_val_o=1, acc_dat_o = lane-wise (acc_dat_i + psum_dat_i).
    - Each lane is an unsigned add modulo 2^LANE_W; no carry crosses lanes.
    - Without a handshake, acc_val_o=0.
    - A beat counter (width 8+SEL_W+1) counts handshakes. The controller leaves for DRAIN in the cycle after the handshake that makes the count reach pass_num*BUF_NUM; psum_rdy_o is 0 from that cycle on.
  - DRAIN: out_sel_o=drain counter, out_val_o=1, out_dat_o=out_dat_i, which gives zero latency from the select.
    - The counter advances on out_val_o & out_rdy_i.
    - When out_rdy_i=0, out_sel_o and out_dat_o hold stable. No writes occur in DRAIN.
    - After the handshake on entry BUF_NUM-1, go to DONE.
  - DONE: one cycle; done_o=1; go to IDLE.
- out_dat_o is 0 whenever out_val_o=0. acc_dat_o is 0 whenever acc_val_o=0.
- start_i is ignored outside IDLE.
- Back-to-back beats to the same entry are legal. The write lands at the clock edge, so the next cycle's acc_dat_i already reflects it.
- The beat order within ACCUM is unconstrained. The controller does not check per-entry pass counts, only the total beat count.
- psum_sel_i >= BUF_NUM (possible only when BUF_NUM is not a power of 2): the beat is accepted and counted, acc_val_o=0, and nothing is written.
- Throughput: 1 beat/cycle in ACCUM and in DRAIN.
- Tile cycle count with no stalls: 1 + BUF_NUM + pass_num*BUF_NUM + BUF_NUM + 1. This counts the cycle start is sampled in IDLE, then CLEAR, ACCUM, DRAIN and DONE.

Test Plan:
- Basic accumulate (BUF_NUM=4, DAT_W=64, LANE_W=16): pass_num=2, send sel 0,1,2,3,0,1,2,3, each lane 0x0001, with out_rdy_i=1 → drain yields 4 beats, sel 0..3, each 0x0002_0002_0002_0002; done_o pulses once; busy_o falls the cycle after done_o.
- Lane wrap: pass_num=2, entry 0 gets lanes 0xFFFF then 0x0003 → entry 0 drains 0x0002 in every lane with no carry into the neighbouring lane; other entries drain 0.
- Drain backpressure: hold out_rdy_i=0 for 3 cycles on entry 1 → out_sel_o=1 and out_dat_o stay constant; exactly 4 drain handshakes occur, in order 0,1,2,3.
- pass_num=0: start → CLEAR (4 cycles, acc_val_o=1, acc_dat_o=0) → DRAIN of 4 zero beats → done_o; psum_rdy_o never asserts.
- Reset mid-ACCUM: assert rst_i after 3 of 8 beats → all outputs 0 asynchronously, before the next edge; a new start with pass_num=1 clears and accumulates correctly, with no stale partial sums.
- Start while busy and same-entry streaming: start_i pulses during ACCUM have no effect; 4 consecutive beats to sel 2 with value 0x0005 per lane, pass_num=1 (4 beats total) → entry 2 drains 0x0014 per lane, other entries drain 0.
